coef_bank_loader: RTL and testbench

Parametrised, double-buffered coefficient bank for the filter datapath. The host writes coefficients a page of `PAGE_WORDS` words at a time into a shadow bank, or selects bypass with page 0. An explicit commit copies the shadow bank into the active bank in a single cycle, aligned to a sample boundary. The filter therefore never runs on a half-updated tap set. The block sits between the host-side PIO registers and the filter's coefficient and bypass inputs.

---
 rtl/coef_bank_loader.sv | 118 +++++++++++
 tb/tb_coef_bank_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coef_bank_loader.sv
`default_nettype none
// ============================================================================
// Module   : coef_bank_loader
// Purpose  : Double-buffered filter coefficient bank with paged shadow loads
//            and a sample-aligned single-cycle commit to the active bank.
// Revision : 1.0
// ============================================================================
module coef_bank_loader #(
    parameter int WIDTH       = 32,
    parameter int N_COEF      = 33,
    parameter int PAGE_WORDS  = 10,
    parameter int SYNC_COMMIT = 1,
    localparam int N_PAGES    = (N_COEF + PAGE_WORDS - 1) / PAGE_WORDS
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         load_valid_i,
    input  logic [7:0]                   load_page_i,
    input  logic [PAGE_WORDS*WIDTH-1:0]  load_data_i,
    input  logic                         commit_i,
    input  logic                         sample_tick_i,
    output logic [N_COEF*WIDTH-1:0]      coef_o,
    output logic                         bypass_filter_o,
    output logic                         coef_update_o,
    output logic                         busy_o,
    output logic                         load_err_o,
    output logic [N_PAGES:0]             pages_loaded_o
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;
    localparam logic [7:0] c_last_page = 8'(N_PAGES);

    logic [0:0]              state_q, state_d;
    logic                    apply, load_ok;
    logic                    load_err_d, coef_update_d, busy_d;
    logic [N_PAGES:0]        pages_d, pages_q;
    logic [N_COEF*WIDTH-1:0] shadow_q, active_q;
    logic                    shadow_byp_q, active_byp_q;
    logic                    coef_update_q, busy_q, load_err_q;

    // Without SYNC_COMMIT the apply fires on the first edge spent in PENDING.
    assign apply = (state_q == PENDING) && (sample_tick_i || (SYNC_COMMIT == 0));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (commit_i) state_d = PENDING;
            PENDING: if (apply)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ok       = load_valid_i && (state_q == IDLE) && (load_page_i <= c_last_page);
        load_err_d    = load_valid_i && !load_ok;
        coef_update_d = apply;
        busy_d        = (state_d == PENDING);
        pages_d       = pages_q;
        if (apply) begin
            pages_d = '0;
        end else if (load_ok) begin
            pages_d = pages_q | ((N_PAGES+1)'(1) << load_page_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            shadow_q      <= '0;
            active_q      <= '0;
            shadow_byp_q  <= 1'b1;
            active_byp_q  <= 1'b1;
            pages_q       <= '0;
            busy_q        <= 1'b0;
            coef_update_q <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            pages_q       <= pages_d;
            busy_q        <= busy_d;
            coef_update_q <= coef_update_d;
            load_err_q    <= load_err_d;
            if (load_ok) begin
                if (load_page_i == 8'd0) begin
                    shadow_byp_q <= 1'b1;
                end else begin
                    shadow_byp_q <= 1'b0;
                    // Words past N_COEF on the last page map to no coefficient.
                    for (int i = 0; i < N_COEF; i++) begin
                        if (load_page_i == 8'(i / PAGE_WORDS + 1)) begin
                            shadow_q[i*WIDTH +: WIDTH] <= load_data_i[(i % PAGE_WORDS)*WIDTH +: WIDTH];
                        end
                    end
                end
            end
            if (apply) begin
                active_q     <= shadow_q;
                active_byp_q <= shadow_byp_q;
            end
        end
    end

    assign coef_o          = active_q;
    assign bypass_filter_o = active_byp_q;
    assign coef_update_o   = coef_update_q;
    assign busy_o          = busy_q;
    assign load_err_o      = load_err_q;
    assign pages_loaded_o  = pages_q;

endmodule
`default_nettype wire

// File: tb/tb_coef_bank_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_coef_bank_loader
// Purpose  : Checks a synchronous-commit and an immediate-commit instance
//            against a behavioural bank model.
// Revision : 1.0
// ============================================================================
module tb_coef_bank_loader;

    localparam int W  = 32;
    localparam int NC = 33;
    localparam int PW = 10;
    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              load_valid = 1'b0;
    logic [7:0]        load_page = 8'd0;
    logic [PW*W-1:0]   load_data = '0;
    logic              commit = 1'b0;
    logic              sample_tick = 1'b0;

    logic [NC*W-1:0]   coef_w [2];
    logic              byp_w  [2];
    logic              upd_w  [2];
    logic              busy_w [2];
    logic              err_w  [2];
    logic [NP:0]       pages_w[2];

    int total = 0;
    int bad   = 0;

    // Model state, index 0 = SYNC_COMMIT=1 instance, index 1 = SYNC_COMMIT=0
    logic [W-1:0] m_sh [2][NC];
    logic [W-1:0] m_act[2][NC];
    bit           m_shb[2], m_actb[2], m_pend[2];
    bit [NP:0]    m_pages[2];
    logic [NC*W-1:0] trunc_exp;

    always #5 clk = ~clk;

    coef_bank_loader #(.WIDTH(W), .N_COEF(NC), .PAGE_WORDS(PW), .SYNC_COMMIT(1)) u_sync (
        .clk_i(clk), .reset_n_i(reset_n), .load_valid_i(load_valid), .load_page_i(load_page),
        .load_data_i(load_data), .commit_i(commit), .sample_tick_i(sample_tick),
        .coef_o(coef_w[0]), .bypass_filter_o(byp_w[0]), .coef_update_o(upd_w[0]),
        .busy_o(busy_w[0]), .load_err_o(err_w[0]), .pages_loaded_o(pages_w[0]));

    coef_bank_loader #(.WIDTH(W), .N_COEF(NC), .PAGE_WORDS(PW), .SYNC_COMMIT(0)) u_async (
        .clk_i(clk), .reset_n_i(reset_n), .load_valid_i(load_valid), .load_page_i(load_page),
        .load_data_i(load_data), .commit_i(commit), .sample_tick_i(sample_tick),
        .coef_o(coef_w[1]), .bypass_filter_o(byp_w[1]), .coef_update_o(upd_w[1]),
        .busy_o(busy_w[1]), .load_err_o(err_w[1]), .pages_loaded_o(pages_w[1]));

    bit m_upd[2], m_err[2];

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (!reset_n) begin
                for (int i = 0; i < NC; i++) begin
                    m_sh[c][i]  = '0;
                    m_act[c][i] = '0;
                end
                m_shb[c] = 1; m_actb[c] = 1; m_pend[c] = 0;
                m_upd[c] = 0; m_err[c] = 0; m_pages[c] = '0;
            end else begin
                bit was_pend;
                int pg;
                was_pend = m_pend[c];
                pg       = int'(load_page);
                m_err[c] = load_valid && (was_pend || pg > NP);
                m_upd[c] = 0;
                if (was_pend && (sample_tick || c == 1)) begin
                    for (int i = 0; i < NC; i++) m_act[c][i] = m_sh[c][i];
                    m_actb[c]  = m_shb[c];
                    m_pages[c] = '0;
                    m_upd[c]   = 1;
                    m_pend[c]  = 0;
                end
                if (load_valid && !was_pend && pg <= NP) begin
                    if (pg == 0) begin
                        m_shb[c] = 1;
                    end else begin
                        for (int j = 0; j < PW; j++) begin
                            if ((pg-1)*PW + j < NC) m_sh[c][(pg-1)*PW + j] = load_data[j*W +: W];
                        end
                        m_shb[c] = 0;
                    end
                    m_pages[c][pg] = 1;
                end
                if (commit && !was_pend) m_pend[c] = 1;
            end
        end
    endtask

    function automatic logic [NC*W-1:0] exp_coef(int c);
        logic [NC*W-1:0] v;
        for (int i = 0; i < NC; i++) v[i*W +: W] = m_act[c][i];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        load_valid  = 0;
        commit      = 0;
        sample_tick = 0;
    endtask

    task automatic do_load(input int page, input logic [PW*W-1:0] data);
        load_valid = 1;
        load_page  = 8'(page);
        load_data  = data;
        step();
    endtask

    task automatic test_reset();
        reset_n = 0;
        step(); step();
        reset_n = 1;
        repeat (5) step();
        for (int c = 0; c < 2; c++) begin
            total++; if (coef_w[c] !== '0) begin bad++; $display("FAIL reset_coef[%0d] got=%h want=0", c, coef_w[c]); end
            total++; if (byp_w[c] !== 1'b1) begin bad++; $display("FAIL reset_bypass[%0d] got=%b want=1", c, byp_w[c]); end
            total++; if (busy_w[c] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b want=0", c, busy_w[c]); end
            total++; if (pages_w[c] !== '0) begin bad++; $display("FAIL reset_pages[%0d] got=%b want=0", c, pages_w[c]); end
        end
    endtask

    task automatic test_full_load_sync();
        logic [PW*W-1:0] d;
        logic [NC*W-1:0] e;
        int busy_low, upd_seen;
        for (int p = 1; p <= NP; p++) begin
            for (int j = 0; j < PW; j++) d[j*W +: W] = 32'(100 + (p-1)*PW + j);
            do_load(p, d);
        end
        total++; if (pages_w[0] !== 5'b11110) begin bad++; $display("FAIL full_pages got=%b want=11110", pages_w[0]); end
        commit = 1;
        step();
        busy_low = 0; upd_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (busy_w[0] !== 1'b1) busy_low++;
            if (upd_w[0] !== 1'b0) upd_seen++;
            step();
        end
        total++; if (busy_low != 0) begin bad++; $display("FAIL full_busy_wait low_cycles=%0d want=0", busy_low); end
        total++; if (upd_seen != 0) begin bad++; $display("FAIL full_early_update pulses=%0d want=0", upd_seen); end
        sample_tick = 1;
        step();
        for (int i = 0; i < NC; i++) e[i*W +: W] = 32'(100 + i);
        total++; if (coef_w[0] !== e) begin bad++; $display("FAIL full_coef got=%h want=%h", coef_w[0], e); end
        total++; if (byp_w[0] !== 1'b0) begin bad++; $display("FAIL full_bypass got=%b want=0", byp_w[0]); end
        total++; if (upd_w[0] !== 1'b1) begin bad++; $display("FAIL full_update got=%b want=1", upd_w[0]); end
        total++; if (busy_w[0] !== 1'b0) begin bad++; $display("FAIL full_busy_end got=%b want=0", busy_w[0]); end
        total++; if (coef_w[1] !== e) begin bad++; $display("FAIL full_coef_async got=%h want=%h", coef_w[1], e); end
        step();
        total++; if (upd_w[0] !== 1'b0) begin bad++; $display("FAIL full_single_pulse got=%b want=0", upd_w[0]); end
    endtask

    task automatic test_truncation();
        logic [PW*W-1:0] d;
        for (int j = 0; j < PW; j++) d[j*W +: W] = 32'(8'hA0 + j);
        do_load(4, d);
        commit = 1;
        step();
        sample_tick = 1;
        step();
        for (int i = 0; i < NC; i++) trunc_exp[i*W +: W] = (i < 30) ? 32'(100 + i) : 32'(8'hA0 + i - 30);
        total++; if (coef_w[0] !== trunc_exp) begin bad++; $display("FAIL trunc_coef got=%h want=%h", coef_w[0], trunc_exp); end
        total++; if (pages_w[0] !== '0) begin bad++; $display("FAIL trunc_pages got=%b want=0", pages_w[0]); end
    endtask

    task automatic test_rejected();
        logic [PW*W-1:0] d;
        for (int j = 0; j < PW; j++) d[j*W +: W] = $urandom;
        do_load(5, d);
        total++; if (err_w[0] !== 1'b1 || err_w[1] !== 1'b1) begin bad++; $display("FAIL rej_page5_err got=%b%b want=11", err_w[0], err_w[1]); end
        total++; if (pages_w[0] !== '0) begin bad++; $display("FAIL rej_page5_pages got=%b want=0", pages_w[0]); end
        step();
        total++; if (err_w[0] !== 1'b0) begin bad++; $display("FAIL rej_err_pulse got=%b want=0", err_w[0]); end
        commit = 1;
        step();
        for (int j = 0; j < PW; j++) d[j*W +: W] = 32'hDEADBEEF;
        do_load(1, d);
        total++; if (err_w[0] !== 1'b1) begin bad++; $display("FAIL rej_pending_err got=%b want=1", err_w[0]); end
        total++; if (pages_w[0] !== '0) begin bad++; $display("FAIL rej_pending_pages got=%b want=0", pages_w[0]); end
        sample_tick = 1;
        step();
        total++; if (coef_w[0] !== trunc_exp) begin bad++; $display("FAIL rej_prior_shadow got=%h want=%h", coef_w[0], trunc_exp); end
        total++; if (coef_w[1] !== exp_coef(1)) begin bad++; $display("FAIL rej_async_coef got=%h want=%h", coef_w[1], exp_coef(1)); end
    endtask

    task automatic test_bypass_async();
        do_load(0, '0);
        total++; if (pages_w[1] !== 5'b00001) begin bad++; $display("FAIL byp_pages got=%b want=00001", pages_w[1]); end
        commit = 1;
        step();
        total++; if (busy_w[1] !== 1'b1 || byp_w[1] !== 1'b0) begin bad++; $display("FAIL byp_edge1 busy/byp got=%b%b want=10", busy_w[1], byp_w[1]); end
        step();
        total++; if (byp_w[1] !== 1'b1) begin bad++; $display("FAIL byp_edge2 got=%b want=1", byp_w[1]); end
        total++; if (upd_w[1] !== 1'b1 || busy_w[1] !== 1'b0) begin bad++; $display("FAIL byp_upd_busy got=%b%b want=10", upd_w[1], busy_w[1]); end
        total++; if (coef_w[1] !== trunc_exp) begin bad++; $display("FAIL byp_coef_kept got=%h want=%h", coef_w[1], trunc_exp); end
    endtask

    task automatic test_reset_pending();
        commit = 1;
        step();
        total++; if (busy_w[0] !== 1'b1) begin bad++; $display("FAIL rstp_busy_pre got=%b want=1", busy_w[0]); end
        reset_n = 0;
        step();
        reset_n = 1;
        total++; if (busy_w[0] !== 1'b0 || byp_w[0] !== 1'b1) begin bad++; $display("FAIL rstp_after busy/byp got=%b%b want=01", busy_w[0], byp_w[0]); end
        sample_tick = 1;
        step();
        total++; if (upd_w[0] !== 1'b0 || coef_w[0] !== '0) begin bad++; $display("FAIL rstp_no_apply upd=%b coef=%h want upd=0 coef=0", upd_w[0], coef_w[0]); end
        total++; if (busy_w[0] !== 1'b0 || byp_w[0] !== 1'b1) begin bad++; $display("FAIL rstp_hold busy/byp got=%b%b want=01", busy_w[0], byp_w[0]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset_n     = ($urandom_range(0, 99) != 0);
            load_valid  = ($urandom_range(0, 2) == 0);
            load_page   = 8'($urandom_range(0, 6));
            for (int j = 0; j < PW; j++) load_data[j*W +: W] = $urandom;
            commit      = ($urandom_range(0, 7) == 0);
            sample_tick = ($urandom_range(0, 3) == 0);
            step();
            for (int c = 0; c < 2; c++) begin
                total++; if (coef_w[c] !== exp_coef(c)) begin bad++; $display("FAIL rnd_coef[%0d] n=%0d got=%h want=%h", c, n, coef_w[c], exp_coef(c)); end
                total++;
                if (byp_w[c] !== m_actb[c] || upd_w[c] !== m_upd[c] || busy_w[c] !== m_pend[c] ||
                    err_w[c] !== m_err[c] || pages_w[c] !== m_pages[c]) begin
                    bad++;
                    $display("FAIL rnd_ctrl[%0d] n=%0d got byp=%b upd=%b busy=%b err=%b pages=%b want byp=%b upd=%b busy=%b err=%b pages=%b",
                             c, n, byp_w[c], upd_w[c], busy_w[c], err_w[c], pages_w[c],
                             m_actb[c], m_upd[c], m_pend[c], m_err[c], m_pages[c]);
                end
            end
        end
        reset_n = 1;
    endtask

    initial begin
        test_reset();
        test_full_load_sync();
        test_truncation();
        test_rejected();
        test_bypass_async();
        test_reset_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
